// File: rtl/parking_pkg.sv
// Shared types and width helpers for the parking lane controller.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, WAIT_CLEAR} gate_state_t;

  function automatic int cnt_width(input int capacity);
    return $clog2(capacity + 1);
  endfunction

  function automatic int tmr_width(input int gate_time);
    return $clog2(gate_time + 1);
  endfunction

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier lane: sensor rising-edge detect, open/hold FSM and minimum-open timer.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int GATE_TIME = 25000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor,
  input  logic allow,
  output logic gate,
  output logic accept,
  output logic edge_idle
);

  localparam int TW = tmr_width(GATE_TIME);

  gate_state_t   state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          sensor_q;
  logic          rise;

  assign rise      = sensor & ~sensor_q;
  assign edge_idle = rise & (state == IDLE);
  assign accept    = edge_idle & allow;
  assign gate      = (state != IDLE);

  // sensor_q resets high so a sensor already asserted at release is not an edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      sensor_q <= 1'b1;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      sensor_q <= sensor;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      IDLE: if (accept) begin
        state_nxt = OPEN;
        timer_nxt = TW'(GATE_TIME - 1);
      end
      OPEN: begin
        if (timer == '0) state_nxt = sensor ? WAIT_CLEAR : IDLE;
        else             timer_nxt = timer - TW'(1);
      end
      WAIT_CLEAR: if (!sensor) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/parking_lane_controller.sv
// Two-lane car-park controller: occupancy, status flags, reject pulse and traffic statistics.
module parking_lane_controller
  import parking_pkg::*;
#(
  parameter int CAPACITY       = 20,
  parameter int INIT_OCCUPIED  = 0,
  parameter int GATE_TIME      = 25000,
  parameter int ALMOST_FULL_TH = 2,
  parameter int STAT_W         = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             entry_sensor,
  input  logic                             exit_sensor,
  output logic                             entry_gate,
  output logic                             exit_gate,
  output logic [cnt_width(CAPACITY)-1:0]   occupancy,
  output logic [cnt_width(CAPACITY)-1:0]   available_spaces,
  output logic                             parking_full,
  output logic                             parking_empty,
  output logic                             almost_full,
  output logic                             entry_reject,
  output logic [STAT_W-1:0]                total_entries,
  output logic [STAT_W-1:0]                total_exits
);

  localparam int CNT_W = cnt_width(CAPACITY);

  logic entry_accept, entry_edge_idle;
  logic exit_accept, exit_edge_idle;

  // Flags come straight from the occupancy register, so accept decisions use last cycle's count
  assign parking_full     = (occupancy == CNT_W'(CAPACITY));
  assign parking_empty    = (occupancy == '0);
  assign available_spaces = CNT_W'(CAPACITY) - occupancy;
  assign almost_full      = (32'(available_spaces) <= 32'(ALMOST_FULL_TH));

  parking_gate_fsm #(.GATE_TIME(GATE_TIME)) u_entry (
    .clk       (clk),
    .reset     (reset),
    .sensor    (entry_sensor),
    .allow     (~parking_full),
    .gate      (entry_gate),
    .accept    (entry_accept),
    .edge_idle (entry_edge_idle)
  );

  parking_gate_fsm #(.GATE_TIME(GATE_TIME)) u_exit (
    .clk       (clk),
    .reset     (reset),
    .sensor    (exit_sensor),
    .allow     (~parking_empty),
    .gate      (exit_gate),
    .accept    (exit_accept),
    .edge_idle (exit_edge_idle)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy     <= CNT_W'(INIT_OCCUPIED);
      total_entries <= '0;
      total_exits   <= '0;
      entry_reject  <= 1'b0;
    end else begin
      entry_reject <= entry_edge_idle & parking_full;
      if (entry_accept & ~exit_accept)      occupancy <= occupancy + CNT_W'(1);
      else if (exit_accept & ~entry_accept) occupancy <= occupancy - CNT_W'(1);
      if (entry_accept) total_entries <= total_entries + STAT_W'(1);
      if (exit_accept)  total_exits   <= total_exits + STAT_W'(1);
    end
  end

endmodule
